// File: rtl/rv32_decode_stage_pkg.sv
// Shared opcode, funct7 and ALU control codes for the RV32 ID stage.
// Also holds the decoded control bundle and the pipeline beat layout.
package rv32_decode_stage_pkg;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;

   localparam logic [1:0] ALU_MUX_R     = 2'd0;
   localparam logic [1:0] ALU_MUX_I     = 2'd1;
   localparam logic [1:0] ALU_MUX_AUIPC = 2'd2;
   localparam logic [1:0] ALU_MUX_LUI   = 2'd3;

   typedef struct packed {
      logic [4:0]  alu_op;
      logic [1:0]  mode;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        non_alu;
      logic        illegal;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      ctrl_t       ctrl;
   } beat_t;

   // alt selects SUB/SRA on the funct3 slots that have an alternate encoding
   function automatic logic [4:0] f3_to_alu(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32_decode_stage_alu_decoder.sv
// Combinational RV32I ALU-class decoder: raw instruction to EX control bundle.
// Zero latency; no flow control of its own.
module rv32_alu_decoder
   import rv32_decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl
);

   logic [6:0]  opcode;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic        alu_class;
   logic        non_alu;
   logic [4:0]  op;
   logic [1:0]  mode;
   logic [31:0] imm;
   logic [4:0]  rs1;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   always_comb begin
      alu_class = 1'b0;
      non_alu   = 1'b0;
      op        = ALU_ADD;
      mode      = ALU_MUX_I;
      imm       = 32'd0;
      rs1       = instr[19:15];
      case (opcode)
         OPC_OP: begin
            mode      = ALU_MUX_R;
            op        = f3_to_alu(f3, f7[5]);
            alu_class = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            op        = f3_to_alu(f3, 1'b0);
            imm       = {{20{instr[31]}}, instr[31:20]};
            alu_class = 1'b1;
            // shifts reuse the upper immediate bits as funct7
            if (f3 == 3'b001) begin
               imm       = {27'd0, instr[24:20]};
               alu_class = (f7 == F7_BASE);
            end else if (f3 == 3'b101) begin
               imm       = {27'd0, instr[24:20]};
               op        = f3_to_alu(f3, f7 == F7_ALT);
               alu_class = (f7 == F7_BASE) || (f7 == F7_ALT);
            end
         end
         OPC_LUI: begin
            rs1       = 5'd0;
            imm       = {instr[31:12], 12'd0};
            alu_class = 1'b1;
         end
         OPC_AUIPC: begin
            mode      = ALU_MUX_AUIPC;
            imm       = {instr[31:12], 12'd0};
            alu_class = 1'b1;
         end
         OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
         OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: non_alu = 1'b1;
         default: ;
      endcase

      ctrl           = '0;
      ctrl.alu_op    = alu_class ? op : ALU_ADD;
      ctrl.mode      = alu_class ? mode : ALU_MUX_I;
      ctrl.imm       = alu_class ? imm : 32'd0;
      ctrl.rs1       = rs1;
      ctrl.rs2       = instr[24:20];
      ctrl.rd        = instr[11:7];
      ctrl.reg_write = alu_class && (instr[11:7] != 5'd0);
      ctrl.non_alu   = non_alu;
      ctrl.illegal   = !alu_class && !non_alu;
   end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 ID stage: decode ahead of a registered valid/ready boundary to EX, 1-cycle latency.
// Optional 2-entry skid keeps if_ready_out registered; flush drops everything held.
module rv32_decode_stage
   import rv32_decode_stage_pkg::*;
#(
   parameter int SKID_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_in,
   input  logic        if_valid_in,
   output logic        if_ready_out,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   output logic        ex_valid_out,
   input  logic        ex_ready_in,
   output logic [31:0] pc_ex_out,
   output logic [4:0]  alu_op_out,
   output logic [1:0]  alu_mode_select_out,
   output logic [31:0] imm_data_out,
   output logic [4:0]  rs1_addr_out,
   output logic [4:0]  rs2_addr_out,
   output logic [4:0]  rd_addr_out,
   output logic        reg_write_out,
   output logic        non_alu_out,
   output logic        illegal_instr_out
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   ctrl_t      dec;
   beat_t      in_beat;
   beat_t      main_q;
   beat_t      skid_q;
   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       rdy_q;
   logic       accept;
   logic       pop;

   rv32_alu_decoder u_dec (
      .instr (instr_in),
      .ctrl  (dec)
   );

   assign in_beat      = {pc_in, dec};
   assign ex_valid_out = (state != ST_EMPTY);
   assign pop          = ex_valid_out && ex_ready_in;
   assign accept       = if_valid_in && if_ready_out;

   // rdy_q also keeps ready low while in reset in the single-register variant
   generate
      if (SKID_EN != 0) begin : g_skid
         assign if_ready_out = rdy_q;
      end else begin : g_noskid
         assign if_ready_out = rdy_q && (!ex_valid_out || ex_ready_in);
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_ONE;
         ST_ONE: begin
            if (accept && !pop)      state_nxt = ST_TWO;
            else if (!accept && pop) state_nxt = ST_EMPTY;
         end
         ST_TWO:   if (pop) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_EMPTY;
         rdy_q  <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush_in) begin
         state <= ST_EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         rdy_q <= (SKID_EN == 0) || (state_nxt != ST_TWO);
         if (accept && ((state == ST_EMPTY) || pop))
            main_q <= in_beat;
         else if ((state == ST_TWO) && pop)
            main_q <= skid_q;
         if (accept && (state == ST_ONE) && !pop)
            skid_q <= in_beat;
      end
   end

   assign pc_ex_out           = main_q.pc;
   assign alu_op_out          = main_q.ctrl.alu_op;
   assign alu_mode_select_out = main_q.ctrl.mode;
   assign imm_data_out        = main_q.ctrl.imm;
   assign rs1_addr_out        = main_q.ctrl.rs1;
   assign rs2_addr_out        = main_q.ctrl.rs2;
   assign rd_addr_out         = main_q.ctrl.rd;
   assign reg_write_out       = main_q.ctrl.reg_write;
   assign non_alu_out         = main_q.ctrl.non_alu;
   assign illegal_instr_out   = main_q.ctrl.illegal;

endmodule
